wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
// - Writeback stage directly downstream of the execute stage; owns the register-file write port.
// - ALU results: registered and written back one cycle after acceptance.
// - Loads: tracks the outstanding data response; aligns and sign/zero-extends data_rdata_i per
//   lsu_type; stalls upstream until the response arrives or times out.
// PARAMETERS
// - RVALID_TIMEOUT  16  max cycles in WAIT_RVALID before abort; 0 = never time out
// PORTS
// clk_i            in   1   clock, all state on rising edge
// rst_i            in   1   async active-high reset
// ex_valid_i       in   1   EX presents a retiring instruction this cycle
// ex_reg_we_i      in   1   instruction writes rd
// ex_wr_addr_i     in   5   rd index
// ex_wdata_i       in   32  ALU result (ignored for loads)
// ex_load_i        in   1   instruction is a load
// ex_lsu_type_i    in   3   funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
// ex_addr_lo_i     in   2   load byte address [1:0]
// data_rvalid_i    in   1   load data valid from memory
// data_rdata_i     in   32  load data word
// stall_o          out  1   upstream must hold; EX instruction not accepted
// rf_we_o          out  1   register-file write enable (1-cycle pulse)
// rf_waddr_o       out  5   register-file write index
// rf_wdata_o       out  32  register-file write data
// load_err_o       out  1   1-cycle pulse: misaligned/illegal load or timeout
// fwd_valid_o/fwd_addr_o[5]/fwd_data_o[32]  out  bypass to ID; present only with WB_FWD_EN
// BEHAVIOUR
// - Reset (rst_i high, async): state IDLE, counter 0; all outputs 0.
// - Accept = ex_valid_i && !stall_o. stall_o = (state == WAIT_RVALID), combinational from state.
// - IDLE, accept, !ex_load_i: next cycle rf_we_o = ex_reg_we_i && (ex_wr_addr_i != 0),
//   rf_waddr_o/rf_wdata_o = captured values. Latency 1; back-to-back accepts allowed.
// - IDLE, accept, ex_load_i: capture rd, type, addr_lo; go to WAIT_RVALID; counter cleared.
// - IDLE: data_rvalid_i ignored.
// - WAIT_RVALID, data_rvalid_i: next cycle rf_we_o = 1 (only if rd != 0) with extracted data;
//   state returns to IDLE on the same edge, so stall_o drops the cycle rf_we_o pulses.
// - Extraction:
//   - LB/LBU: byte = rdata[8*addr_lo +: 8], sign- or zero-extended.
//   - LH/LHU: half = rdata[16*addr_lo[1] +: 16], extended likewise.
//   - LW: whole word.
// - Error, misaligned: LH/LHU with addr_lo[0] = 1, or LW with addr_lo != 0.
// - Error, illegal type: 011, 110, 111.
// - On error the load still waits for data_rvalid_i; on arrival load_err_o pulses instead of
//   rf_we_o, and no write occurs.
// - Timeout: counter increments each WAIT_RVALID cycle without rvalid.
//   - Counter reaches RVALID_TIMEOUT: load_err_o pulses, no write, state -> IDLE.
//   - rvalid arriving on the timeout cycle wins: normal write, no error.
//   - Counter saturates; it never wraps.
// - Reset mid-WAIT: pending load discarded; no write or error after reset release.
// - Outputs are registered, except stall_o.
// CONFIGURATION
// - WB_FWD_EN defined: fwd_valid_o = rf_we_o, fwd_addr_o = rf_waddr_o, fwd_data_o = rf_wdata_o
//   (same registers; ID bypasses same-cycle RF write).
// - WB_FWD_EN undefined: fwd_* ports and logic absent; ID relies on RF write-through.
// TESTING
// - ALU: accept x5 = 0x1234_5678 -> next cycle rf_we_o = 1, waddr 5, wdata 0x12345678; stall_o never high.
// - rd = x0 ALU write (wdata 0xFFFF_FFFF) -> rf_we_o stays 0.
// - LB, addr_lo = 2, rdata 0x0080_0000 after 3 wait cycles -> stall_o high 3 cycles + rvalid cycle;
//   then wdata 0xFFFF_FF80.
// - LHU, addr_lo = 2, rdata 0x8001_0000 -> wdata 0x0000_8001.
// - LW, addr_lo = 1, rvalid after 1 cycle -> load_err_o 1 pulse, rf_we_o 0.
// - RVALID_TIMEOUT = 4, LW with no rvalid -> load_err_o pulse when counter reaches 4, stall_o drops.
// - Late rvalid after abort: ignored in IDLE.
// - Reset asserted while in WAIT, then rvalid -> no rf_we_o, no load_err_o.

Source files
------------

// File: rtl/wb_stage_if.sv
// wb_stage_if: EX/memory-side bus into the writeback stage
// Purpose: groups the EX retire handshake, load response and register-file write port.
// Signals:
//   ex_valid_i, ex_reg_we_i, ex_wr_addr_i[5], ex_wdata_i[32], ex_load_i,
//   ex_lsu_type_i[3], ex_addr_lo_i[2]     retiring instruction from EX
//   data_rvalid_i, data_rdata_i[32]       load response from memory
//   stall_o                               upstream hold
//   rf_we_o, rf_waddr_o[5], rf_wdata_o[32] register-file write port
//   load_err_o                            load error / timeout pulse
//   fwd_valid_o, fwd_addr_o[5], fwd_data_o[32]  bypass to ID (only with WB_FWD_EN)
// Modports: slave = wb_stage, master = EX/memory side.
interface wb_stage_if;
    logic        ex_valid_i;
    logic        ex_reg_we_i;
    logic [4:0]  ex_wr_addr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_load_i;
    logic [2:0]  ex_lsu_type_i;
    logic [1:0]  ex_addr_lo_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        load_err_o;
`ifdef WB_FWD_EN
    logic        fwd_valid_o;
    logic [4:0]  fwd_addr_o;
    logic [31:0] fwd_data_o;
`endif
    modport slave (
        input  ex_valid_i, ex_reg_we_i, ex_wr_addr_i, ex_wdata_i, ex_load_i,
               ex_lsu_type_i, ex_addr_lo_i, data_rvalid_i, data_rdata_i,
        output stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, load_err_o
`ifdef WB_FWD_EN
        , output fwd_valid_o, fwd_addr_o, fwd_data_o
`endif
    );
    modport master (
        output ex_valid_i, ex_reg_we_i, ex_wr_addr_i, ex_wdata_i, ex_load_i,
               ex_lsu_type_i, ex_addr_lo_i, data_rvalid_i, data_rdata_i,
        input  stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, load_err_o
`ifdef WB_FWD_EN
        , input fwd_valid_o, fwd_addr_o, fwd_data_o
`endif
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: writeback stage owning the register-file write port
// Purpose: registers ALU results for writeback one cycle after acceptance; for loads, waits
//   for the data response (or a timeout), aligns and extends the data, and flags errors.
// Ports:
//   clk_i  clock, all state on rising edge
//   rst_i  asynchronous active-high reset
//   bus    wb_stage_if.slave (EX handshake, load response, RF write port, load_err_o)
// Parameters:
//   RVALID_TIMEOUT  max WAIT_RVALID cycles before abort; 0 = never time out
// Configuration macro:
//   WB_FWD_EN  when defined, drives fwd_* bypass outputs from the RF write registers.
module wb_stage #(
    parameter int RVALID_TIMEOUT = 16
) (
    input logic       clk_i,
    input logic       rst_i,
    wb_stage_if.slave bus
);
    localparam int CW = RVALID_TIMEOUT > 0 ? $clog2(RVALID_TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, WAIT_RVALID} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_rd;
    logic [2:0]      r_type;
    logic [1:0]      r_lo;
    logic            r_err;
    logic            r_we;
    logic [4:0]      r_waddr;
    logic [31:0]     r_wdata;
    logic            r_lerr;

    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_ldata;
    logic            w_bad;
    logic            w_timeout;

    assign w_byte  = bus.data_rdata_i[{r_lo, 3'b000} +: 8];
    assign w_half  = bus.data_rdata_i[{r_lo[1], 4'b0000} +: 16];
    // type[2] selects zero-extension (LBU/LHU)
    assign w_ldata = r_type[1:0] == 2'b00 ? {{24{~r_type[2] & w_byte[7]}}, w_byte} :
                     r_type[1:0] == 2'b01 ? {{16{~r_type[2] & w_half[15]}}, w_half} :
                     bus.data_rdata_i;
    // Illegal types 011/110/111, or misaligned half/word access
    assign w_bad   = bus.ex_lsu_type_i == 3'b011 || bus.ex_lsu_type_i[2:1] == 2'b11 ||
                     (bus.ex_lsu_type_i[1:0] == 2'b01 && bus.ex_addr_lo_i[0]) ||
                     (bus.ex_lsu_type_i == 3'b010 && bus.ex_addr_lo_i != 2'b00);
    assign w_timeout = RVALID_TIMEOUT != 0 && r_cnt == CW'(RVALID_TIMEOUT);

    assign bus.stall_o    = r_state == WAIT_RVALID;
    assign bus.rf_we_o    = r_we;
    assign bus.rf_waddr_o = r_waddr;
    assign bus.rf_wdata_o = r_wdata;
    assign bus.load_err_o = r_lerr;
`ifdef WB_FWD_EN
    assign bus.fwd_valid_o = r_we;
    assign bus.fwd_addr_o  = r_waddr;
    assign bus.fwd_data_o  = r_wdata;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rd    <= '0;
            r_type  <= '0;
            r_lo    <= '0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_lerr  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_lerr <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.ex_valid_i && bus.ex_load_i) begin
                    r_state <= WAIT_RVALID;
                    r_cnt   <= '0;
                    r_rd    <= bus.ex_wr_addr_i;
                    r_type  <= bus.ex_lsu_type_i;
                    r_lo    <= bus.ex_addr_lo_i;
                    r_err   <= w_bad;
                end else if (bus.ex_valid_i) begin
                    r_we    <= bus.ex_reg_we_i && bus.ex_wr_addr_i != 5'd0;
                    r_waddr <= bus.ex_wr_addr_i;
                    r_wdata <= bus.ex_wdata_i;
                end
            end else if (bus.data_rvalid_i) begin
                // rvalid wins over a timeout on the same cycle
                r_state <= IDLE;
                r_we    <= !r_err && r_rd != 5'd0;
                r_lerr  <= r_err;
                r_waddr <= r_rd;
                r_wdata <= w_ldata;
            end else if (w_timeout) begin
                r_state <= IDLE;
                r_lerr  <= 1'b1;
            end else begin
                r_cnt <= r_cnt != '1 ? r_cnt + 1'b1 : r_cnt;
            end
        end
    end
endmodule
